// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl
//   Single-clock FIFO for the ISP line/stream buffers. Provides a fill level,
//   programmable almost-full/almost-empty flags, sticky overflow/underflow
//   flags, a synchronous flush and an optional first-word-fall-through mode.
//
// Parameters
//   DW      data width in bits
//   AW      address width, DEPTH = 2**AW words
//   FWFT    0 = registered read (1-cycle latency), 1 = first-word-fall-through
//   AF_LVL  walmost_full asserts when level >= AF_LVL
//   AE_LVL  ralmost_empty asserts when level <= AE_LVL
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active high
//   flush          synchronous clear of contents and error flags
//   wen / wdata    write request and data
//   wfull          level == DEPTH
//   walmost_full   level >= AF_LVL
//   ren            read request (FWFT: pop of the presented word)
//   rdata          read data
//   rempty         no word readable
//   ralmost_empty  level <= AE_LVL
//   level          words accepted and not yet popped, 0..DEPTH
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
module sync_fifo_lvl #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 5,
    parameter int unsigned FWFT   = 0,
    parameter int unsigned AF_LVL = (2 ** AW) - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wen,
    input  logic [DW-1:0] wdata,
    output logic          wfull,
    output logic          walmost_full,
    input  logic          ren,
    output logic [DW-1:0] rdata,
    output logic          rempty,
    output logic          ralmost_empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [AW:0] DepthLvl = DEPTH[AW:0];
    localparam logic [AW:0] AfLvl    = AF_LVL[AW:0];
    localparam logic [AW:0] AeLvl    = AE_LVL[AW:0];
    localparam bit          FwftMode = (FWFT != 0);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wfull_q, wfull_d;
    logic          walmostFull_q, walmostFull_d;
    logic          rempty_q, rempty_d;
    logic          ralmostEmpty_q, ralmostEmpty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wrAccept;
    logic          rdAccept;
    logic          headValid;
    logic          headValid_d;
    logic [AW:0]   memCount;
    logic          loadHead;

    // Requests are qualified by the registered flags of the current cycle, so a
    // write at full is rejected even when a read pops in the same cycle.
    // In FWFT mode the output register counts toward level, so the words still
    // sitting in the RAM are level minus the presented head word. The head is
    // refilled whenever it is empty or being popped and the RAM has a word.
    assign wrAccept  = wen && !wfull_q;
    assign rdAccept  = ren && !rempty_q;
    assign headValid = FwftMode && !rempty_q;
    assign memCount  = level_q - {{AW{1'b0}}, headValid};
    assign loadHead  = FwftMode && (!headValid || rdAccept) && (memCount != '0);

    // Next-state computation. Flush overrides both requests and clears the
    // error flags without flagging the dropped requests. All flags are derived
    // from the next-state level so they move on the same edge as level.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        level_d     = level_q;
        rdata_d     = rdata_q;
        headValid_d = headValid;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            level_d     = '0;
            headValid_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wen && wfull_q) begin
                overflow_d = 1'b1;
            end
            if (ren && rempty_q) begin
                underflow_d = 1'b1;
            end
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            case ({wrAccept, rdAccept})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (FwftMode) begin
                if (loadHead) begin
                    rdata_d     = mem_q[rdPtr_q];
                    rdPtr_d     = rdPtr_q + 1'b1;
                    headValid_d = 1'b1;
                end else if (rdAccept) begin
                    headValid_d = 1'b0;
                end
            end else if (rdAccept) begin
                rdata_d = mem_q[rdPtr_q];
                rdPtr_d = rdPtr_q + 1'b1;
            end
        end

        wfull_d        = (level_d == DepthLvl);
        walmostFull_d  = (level_d >= AfLvl);
        ralmostEmpty_d = (level_d <= AeLvl);
        rempty_d       = FwftMode ? !headValid_d : (level_d == '0);
    end

    // Storage array. Deliberately not reset so it maps onto block/distributed
    // RAM; its contents are meaningless after reset or flush anyway.
    always_ff @(posedge clk) begin
        if (!flush && wrAccept) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

    // Control and status registers. Reset returns everything to the empty
    // state immediately; almost-full is only set at reset when its threshold is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            level_q        <= '0;
            rdata_q        <= '0;
            wfull_q        <= 1'b0;
            walmostFull_q  <= (AfLvl == '0);
            rempty_q       <= 1'b1;
            ralmostEmpty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wrPtr_q        <= wrPtr_d;
            rdPtr_q        <= rdPtr_d;
            level_q        <= level_d;
            rdata_q        <= rdata_d;
            wfull_q        <= wfull_d;
            walmostFull_q  <= walmostFull_d;
            rempty_q       <= rempty_d;
            ralmostEmpty_q <= ralmostEmpty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign wfull         = wfull_q;
    assign walmost_full  = walmostFull_q;
    assign rdata         = rdata_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmostEmpty_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule
